// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder stream pipeline.
//   DEC_MODE_ONEHOT / DEC_MODE_THERM : encodings of the mode input
//   dec_state_e                      : self-test sweep FSM states
package decoder_pkg;

    localparam logic DEC_MODE_ONEHOT = 1'b0;
    localparam logic DEC_MODE_THERM  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } dec_state_e;

endpackage

// File: rtl/decoder_vec_gen.sv
// Combinational code-to-vector generator.
//   k_i      : IN_W-bit code
//   mode_i   : DEC_MODE_ONEHOT (bit k) or DEC_MODE_THERM (bits k..0)
//   enable_i : 0 forces a zero vector
//   vec_o    : OUT_W-bit decoded vector
//   range_o  : enabled code lies outside 0..OUT_W-1
module decoder_vec_gen
    import decoder_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  k_i,
    input  logic             mode_i,
    input  logic             enable_i,
    output logic [OUT_W-1:0] vec_o,
    output logic             range_o
);

    // Wide enough for both the code and the bit index, so the range check
    // never sees a truncated code.
    localparam int KW = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;

    logic [KW-1:0] k_ext;
    logic          in_range;

    always_comb begin
        k_ext    = KW'(k_i);
        in_range = (k_ext < KW'(OUT_W));
        range_o  = enable_i && !in_range;
        vec_o    = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (enable_i && in_range) begin
                if (mode_i == DEC_MODE_THERM) vec_o[i] = (KW'(i) <= k_ext);
                else                          vec_o[i] = (KW'(i) == k_ext);
            end
        end
    end

endmodule

// File: rtl/decoder_stream_pipe.sv
// Registered IN_W-to-OUT_W decoder with valid/ready on both sides and a
// built-in sweep sequencer that emits every code 0..OUT_W-1 for self-test.
//   clk, reset          : clock, synchronous active-high reset
//   enable, mode        : decode controls, sampled with each accepted input
//   in_valid/in_ready   : input handshake, binary_in carries the code
//   scan_start          : one-cycle sweep request (ignored while busy)
//   scan_busy           : sweep FSM not IDLE
//   out_valid/out_ready : output handshake
//   decoder_out         : decoded vector, out_code: code that produced it
//   range_err           : only with DECODER_RANGE_ERR_EN defined; set for a
//                         beat whose enabled code was >= OUT_W
module decoder_stream_pipe
    import decoder_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  binary_in,
    input  logic             scan_start,
    output logic             scan_busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] decoder_out,
    output logic [IN_W-1:0]  out_code
`ifdef DECODER_RANGE_ERR_EN
    ,
    output logic             range_err
`endif
);

    localparam logic [IN_W-1:0] LAST_CODE = IN_W'(OUT_W - 1);

    dec_state_e        state_q, state_d;
    logic [IN_W-1:0]   cnt_q, cnt_d;
    logic              smode_q, smode_d;

    logic              out_valid_q;
    logic [OUT_W-1:0]  dec_q;
    logic [IN_W-1:0]   code_q;
    logic              rerr_q;

    logic              slot_free, accept, scan_load, load;
    logic [IN_W-1:0]   sel_k;
    logic              sel_mode, sel_en;
    logic [OUT_W-1:0]  vec;
    logic              rerr;

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q == IDLE) && slot_free;
    assign accept    = in_valid && in_ready;
    assign scan_load = (state_q == SCAN) && slot_free;
    assign load      = accept || scan_load;

    // The sweep owns the generator while in SCAN; enable is forced on.
    assign sel_k    = scan_load ? cnt_q   : binary_in;
    assign sel_mode = scan_load ? smode_q : mode;
    assign sel_en   = scan_load ? 1'b1    : enable;

    decoder_vec_gen #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_vec_gen (
        .k_i      (sel_k),
        .mode_i   (sel_mode),
        .enable_i (sel_en),
        .vec_o    (vec),
        .range_o  (rerr)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        smode_d = smode_q;
        case (state_q)
            IDLE: begin
                // An input accepted this same cycle still goes first; the
                // sweep's first load can only happen from SCAN next cycle.
                if (scan_start) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                    smode_d = mode;
                end
            end
            SCAN: begin
                if (slot_free) begin
                    cnt_d = cnt_q + IN_W'(1);
                    if (cnt_q == LAST_CODE) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (slot_free) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            smode_q     <= DEC_MODE_ONEHOT;
            out_valid_q <= 1'b0;
            dec_q       <= '0;
            code_q      <= '0;
            rerr_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            smode_q <= smode_d;
            if (load) begin
                out_valid_q <= 1'b1;
                dec_q       <= vec;
                code_q      <= sel_k;
                rerr_q      <= rerr;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign scan_busy   = (state_q != IDLE);
    assign out_valid   = out_valid_q;
    assign decoder_out = dec_q;
    assign out_code    = code_q;

`ifdef DECODER_RANGE_ERR_EN
    assign range_err = rerr_q;
`else
    logic unused_rerr;
    assign unused_rerr = rerr_q;
`endif

endmodule

// File: tb/tb_decoder_stream_pipe.sv
module tb_decoder_stream_pipe;
    import decoder_pkg::*;

    localparam int IN_W  = 4;
    localparam int OUT_W = 16;
    localparam int W10   = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // main instance, OUT_W=16
    logic             enable = 1'b1, mode = 1'b0, in_valid = 1'b0, scan_start = 1'b0;
    logic             out_ready = 1'b1;
    logic [IN_W-1:0]  binary_in = '0;
    logic             in_ready, scan_busy, out_valid;
    logic [OUT_W-1:0] decoder_out;
    logic [IN_W-1:0]  out_code;
`ifdef DECODER_RANGE_ERR_EN
    logic             range_err;
`endif

    // narrow instance, OUT_W=10, for out-of-range codes
    logic             enable10 = 1'b1, mode10 = 1'b0, in_valid10 = 1'b0;
    logic             out_ready10 = 1'b1, scan_start10 = 1'b0;
    logic [IN_W-1:0]  binary_in10 = '0;
    logic             in_ready10, scan_busy10, out_valid10;
    logic [W10-1:0]   decoder_out10;
    logic [IN_W-1:0]  out_code10;
`ifdef DECODER_RANGE_ERR_EN
    logic             range_err10;
`endif

    decoder_stream_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .binary_in(binary_in),
        .scan_start(scan_start), .scan_busy(scan_busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .decoder_out(decoder_out), .out_code(out_code)
`ifdef DECODER_RANGE_ERR_EN
        , .range_err(range_err)
`endif
    );

    decoder_stream_pipe #(.IN_W(IN_W), .OUT_W(W10)) u_dut10 (
        .clk(clk), .reset(reset), .enable(enable10), .mode(mode10),
        .in_valid(in_valid10), .in_ready(in_ready10), .binary_in(binary_in10),
        .scan_start(scan_start10), .scan_busy(scan_busy10),
        .out_valid(out_valid10), .out_ready(out_ready10),
        .decoder_out(decoder_out10), .out_code(out_code10)
`ifdef DECODER_RANGE_ERR_EN
        , .range_err(range_err10)
`endif
    );

    typedef struct {
        logic [OUT_W-1:0] vec;
        logic [IN_W-1:0]  code;
        logic             rerr;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input int k, input logic m, input logic en, input int w);
        logic [31:0] v;
        v = '0;
        if (en && k < w)
            for (int i = 0; i < w; i++) v[i] = m ? (i <= k) : (i == k);
        return v;
    endfunction

    task automatic push(input int k, input logic m, input logic en);
        exp_t e;
        e.vec  = OUT_W'(model(k, m, en, OUT_W));
        e.code = IN_W'(k);
        e.rerr = 1'b0;
        sbq.push_back(e);
    endtask

    // Scoreboard side: every beat that transfers is compared in order.
    always @(negedge clk) begin
        if (!reset) begin
            if (scan_busy) check("busy_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_beat", 32'(sbq.size()), 32'd1);
                end else begin
                    mon_e = sbq.pop_front();
                    check("vec", 32'(decoder_out), 32'(mon_e.vec));
                    check("code", 32'(out_code), 32'(mon_e.code));
`ifdef DECODER_RANGE_ERR_EN
                    check("rerr", 32'(range_err), 32'(mon_e.rerr));
`endif
                    pops++;
                end
            end
        end
    end

    task automatic send(input int k, input logic m, input logic en);
        bit ok;
        ok = 0;
        in_valid = 1'b1; binary_in = IN_W'(k); mode = m; enable = en;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (ok) push(k, m, en);
        else    check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic scan_pulse(input bit push_it, input logic m);
        scan_start = 1'b1; mode = m;
        @(negedge clk);
        if (push_it) for (int i = 0; i < OUT_W; i++) push(i, m, 1'b1);
        @(posedge clk); #1;
        scan_start = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd);
        bit done;
        done = 0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (!scan_busy && sbq.size() == 0) begin done = 1; break; end
        end
        out_ready = 1'b1;
        check("idle_timeout", 32'(done), 32'd1);
    endtask

    task automatic send10(input int k, input logic m, input logic en);
        in_valid10 = 1'b1; binary_in10 = IN_W'(k); mode10 = m; enable10 = en;
        @(negedge clk);
        check("in_ready10", 32'(in_ready10), 32'd1);
        @(posedge clk); #1;
        in_valid10 = 1'b0;
        check("valid10", 32'(out_valid10), 32'd1);
        check("vec10", 32'(decoder_out10), model(k, m, en, W10));
        check("code10", 32'(out_code10), 32'(k));
`ifdef DECODER_RANGE_ERR_EN
        check("rerr10", 32'(range_err10), 32'(en && k >= W10));
`endif
    endtask

    int p0;

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_vec", 32'(decoder_out), 32'd0);
        check("rst_code", 32'(out_code), 32'd0);
        check("rst_busy", 32'(scan_busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;

        // back-to-back one-hot stream with 1-cycle latency
        send(0, DEC_MODE_ONEHOT, 1'b1);
        check("latency_valid", 32'(out_valid), 32'd1);
        send(5, DEC_MODE_ONEHOT, 1'b1);
        send(15, DEC_MODE_ONEHOT, 1'b1);

        // thermometer and disabled decode
        send(3, DEC_MODE_THERM, 1'b1);
        send(15, DEC_MODE_THERM, 1'b1);
        send(9, DEC_MODE_ONEHOT, 1'b0);

        // backpressure: hold k=7 for 3 cycles with a new input waiting
        send(7, DEC_MODE_ONEHOT, 1'b1);
        out_ready = 1'b0;
        in_valid = 1'b1; binary_in = 4'd2; mode = DEC_MODE_ONEHOT; enable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_vec", 32'(decoder_out), 32'h0080);
            check("bp_code", 32'(out_code), 32'd7);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        if (in_ready) push(2, DEC_MODE_ONEHOT, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_release_vec", 32'(decoder_out), 32'h0004);

        // out-of-range codes on the OUT_W=10 instance
        send10(12, DEC_MODE_ONEHOT, 1'b1);
        send10(9, DEC_MODE_THERM, 1'b1);
        send10(12, DEC_MODE_THERM, 1'b0);
        send10(15, DEC_MODE_THERM, 1'b1);
        send10(0, DEC_MODE_ONEHOT, 1'b1);

        // one-hot sweep with random backpressure, restart attempt, mode change
        @(posedge clk); #1;
        p0 = pops;
        scan_pulse(1'b1, DEC_MODE_ONEHOT);
        check("scan_busy_next", 32'(scan_busy), 32'd1);
        check("scan_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        mode = DEC_MODE_THERM;
        scan_pulse(1'b0, DEC_MODE_THERM);
        wait_idle(1'b1);
        check("scan_beats", 32'(pops - p0), 32'(OUT_W));
        check("scan_done_busy", 32'(scan_busy), 32'd0);

        // scan_start together with an accepted input
        in_valid = 1'b1; binary_in = 4'd4; mode = DEC_MODE_THERM; enable = 1'b1;
        scan_start = 1'b1;
        @(negedge clk);
        check("simul_in_ready", 32'(in_ready), 32'd1);
        push(4, DEC_MODE_THERM, 1'b1);
        for (int i = 0; i < OUT_W; i++) push(i, DEC_MODE_THERM, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0; scan_start = 1'b0;
        check("simul_vec", 32'(decoder_out), 32'h001F);
        wait_idle(1'b0);

        // reset at the 6th sweep beat
        scan_pulse(1'b1, DEC_MODE_THERM);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        sbq.delete();
        @(posedge clk); #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(scan_busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_vec", 32'(decoder_out), 32'd0);
        check("mid_rst_code", 32'(out_code), 32'd0);
        reset = 1'b0;

        // recovery after reset
        send(1, DEC_MODE_ONEHOT, 1'b1);
        send(14, DEC_MODE_THERM, 1'b1);
        @(posedge clk); #1;
        for (int n = 0; n < 20 && sbq.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
